// File: rtl/shift_chain_loader.sv
// Serialises a WIDTH-bit word MSB-first onto shift_clk/shift_dta while capturing the chain's return bit.
// One word per 2*DIV*WIDTH+2 cycles; load_ready is low for the whole transfer and extra load_valid is dropped.
module shift_chain_loader #(
  parameter int WIDTH = 64,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             shift_clk,
  output logic             shift_dta,
  input  logic             shift_ret,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);

  localparam int DW = $clog2(DIV + 1);
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic             last_tick;

  logic shift_clk_nxt, shift_dta_nxt, rx_valid_nxt, load_ready_nxt;

  assign last_tick = (div_cnt == DW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_valid) state_nxt = LOW;
      LOW:     if (last_tick) state_nxt = HIGH;
      HIGH:    if (last_tick) state_nxt = (bit_cnt == BW'(1)) ? DONE : LOW;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so their next values are derived from the next state.
  always_comb begin
    shift_clk_nxt  = (state_nxt == HIGH);
    rx_valid_nxt   = (state_nxt == DONE);
    load_ready_nxt = (state_nxt == IDLE);
    shift_dta_nxt  = shift_dta;
    if (state_nxt == LOW && state != LOW)
      shift_dta_nxt = (state == IDLE) ? load_data[WIDTH-1] : tx_sr[WIDTH-1];
  end

  // tx_sr always holds the bits still to be sent, MSB first; the current bit lives in shift_dta.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_data    <= '0;
      shift_clk  <= 1'b0;
      shift_dta  <= 1'b0;
      rx_valid   <= 1'b0;
      load_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      if (state_nxt != state)
        div_cnt <= DW'(DIV);
      else if (div_cnt != '0)
        div_cnt <= div_cnt - DW'(1);

      case (state)
        IDLE: if (load_valid) begin
          tx_sr   <= {load_data[WIDTH-2:0], 1'b0};
          bit_cnt <= BW'(WIDTH);
        end
        LOW:  if (last_tick) rx_sr <= {rx_sr[WIDTH-2:0], shift_ret};
        HIGH: if (last_tick) begin
          bit_cnt <= bit_cnt - BW'(1);
          tx_sr   <= {tx_sr[WIDTH-2:0], 1'b0};
        end
        default: ;
      endcase

      if (state_nxt == DONE) rx_data <= rx_sr;

      shift_clk  <= shift_clk_nxt;
      shift_dta  <= shift_dta_nxt;
      rx_valid   <= rx_valid_nxt;
      load_ready <= load_ready_nxt;
      busy       <= !load_ready_nxt;
    end
  end

endmodule

// File: tb/tb_shift_chain_loader.sv
// Directed bench: DIV=1 and DIV=4 instances, each driving a behavioural chain model.
module tb_shift_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  rst, lv, lr, sclk, sdta, rxv, bsy;
  logic [63:0] ld0, ld1, rxd0, rxd1;
  logic [63:0] m0 = '0, m1 = '0;
  int          r0 = 0, r1 = 0;

  int vectors = 0;
  int miscompares = 0;

  shift_chain_loader #(.WIDTH(64), .DIV(1)) u_div1 (
    .clk(clk), .rst(rst[0]), .load_valid(lv[0]), .load_ready(lr[0]), .load_data(ld0),
    .shift_clk(sclk[0]), .shift_dta(sdta[0]), .shift_ret(m0[63]),
    .rx_data(rxd0), .rx_valid(rxv[0]), .busy(bsy[0]));

  shift_chain_loader #(.WIDTH(64), .DIV(4)) u_div4 (
    .clk(clk), .rst(rst[1]), .load_valid(lv[1]), .load_ready(lr[1]), .load_data(ld1),
    .shift_clk(sclk[1]), .shift_dta(sdta[1]), .shift_ret(m1[63]),
    .rx_data(rxd1), .rx_valid(rxv[1]), .busy(bsy[1]));

  // Chain models: shift on the rising edge of shift_clk, return bit is the last stage.
  always @(posedge sclk[0]) begin m0 <= {m0[62:0], sdta[0]}; r0 <= r0 + 1; end
  always @(posedge sclk[1]) begin m1 <= {m1[62:0], sdta[1]}; r1 <= r1 + 1; end

  // Waveform monitor for the DIV=4 instance.
  int dta_viol = 0, hi_bad = 0, per_bad = 0, hi_len = 0, last_rise = -1;
  logic p_clk = 1'b0, p_dta = 1'b0;
  always @(negedge clk) begin
    if (sdta[1] !== p_dta && sclk[1] !== 1'b0) dta_viol++;
    if (sclk[1] === 1'b1 && p_clk === 1'b0) begin
      if (last_rise >= 0 && cyc - last_rise != 8) per_bad++;
      last_rise = cyc;
      hi_len = 0;
    end
    if (sclk[1] === 1'b1) hi_len++;
    if (sclk[1] === 1'b0 && p_clk === 1'b1 && hi_len != 4) hi_bad++;
    p_clk = sclk[1];
    p_dta = sdta[1];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents the word for exactly one cycle.
  task automatic do_load(input int d, input logic [63:0] data, output int t);
    chk("ready_before_load", lr[d], 1'b1);
    lv[d] = 1'b1;
    if (d == 0) ld0 = data; else ld1 = data;
    t = cyc;
    @(negedge clk);
    lv[d] = 1'b0;
    chk("busy_after_load", bsy[d], 1'b1);
    chk("ready_low_after_load", lr[d], 1'b0);
  endtask

  task automatic wait_done(input int d, input int t, input int lat);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rxv[d] === 1'b1) begin seen = 1'b1; break; end
    end
    chk("rx_valid_seen", 64'(seen), 64'd1);
    if (seen) chk("rx_valid_latency", 64'(cyc - t), 64'(lat));
    @(negedge clk);
    chk("rx_valid_one_cycle", rxv[d], 1'b0);
    chk("ready_after_done", lr[d], 1'b1);
  endtask

  initial begin
    int t, t2, base, hs, pulses, aborted_pulses;
    bit found;
    logic [63:0] partial, first_rx;

    rst = 2'b11; lv = 2'b00; ld0 = '0; ld1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", lr[0], 1'b1);
    chk("rst_busy", bsy[0], 1'b0);
    chk("rst_sclk", sclk[0], 1'b0);
    chk("rst_sdta", sdta[0], 1'b0);
    chk("rst_rxv", rxv[0], 1'b0);
    chk("rst_rxd", rxd0, 64'd0);
    chk("rst_ready_div4", lr[1], 1'b1);
    chk("rst_rxd_div4", rxd1, 64'd0);
    rst = 2'b00;
    @(negedge clk);

    // DIV=1 transfer into an all-zero chain
    base = r0;
    do_load(0, 64'h0123_4567_89AB_CDEF, t);
    wait_done(0, t, 129);
    chk("t2_rises", 64'(r0 - base), 64'd64);
    chk("t2_chain", m0, 64'h0123_4567_89AB_CDEF);
    chk("t2_rxd", rxd0, 64'd0);

    // back-to-back load reads back the previous word
    do_load(0, 64'hFFFF_0000_FFFF_0000, t);
    wait_done(0, t, 129);
    chk("t3_chain", m0, 64'hFFFF_0000_FFFF_0000);
    chk("t3_rxd", rxd0, 64'h0123_4567_89AB_CDEF);

    // DIV=4 waveform
    base = r1;
    do_load(1, 64'hAAAA_AAAA_AAAA_AAAA, t);
    wait_done(1, t, 513);
    chk("t4_rises", 64'(r1 - base), 64'd64);
    chk("t4_chain", m1, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("t4_rxd", rxd1, 64'd0);
    chk("t4_dta_in_high", 64'(dta_viol), 64'd0);
    chk("t4_high_width", 64'(hi_bad), 64'd0);
    chk("t4_period", 64'(per_bad), 64'd0);

    // abort after 20 rises
    base = r0;
    found = 1'b0;
    do_load(0, 64'h5555_5555_5555_5555, t);
    for (int i = 0; i < 500; i++) begin
      if (r0 - base == 20) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("t5_reached_20", 64'(found), 64'd1);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("t5_sclk_low", sclk[0], 1'b0);
    chk("t5_rxd_cleared", rxd0, 64'd0);
    rst[0] = 1'b0;
    partial = (64'hFFFF_0000_FFFF_0000 << 20) | (64'h5555_5555_5555_5555 >> 44);
    aborted_pulses = 0;
    repeat (200) begin
      @(negedge clk);
      if (rxv[0] === 1'b1) aborted_pulses++;
    end
    chk("t5_no_rx_valid", 64'(aborted_pulses), 64'd0);
    chk("t5_ready", lr[0], 1'b1);
    chk("t5_chain_partial", m0, partial);
    do_load(0, 64'h0F1E_2D3C_4B5A_6978, t);
    wait_done(0, t, 129);
    chk("t5_fresh_chain", m0, 64'h0F1E_2D3C_4B5A_6978);
    chk("t5_fresh_rxd", rxd0, partial);

    // reset and load_valid together: reset wins
    base = r0;
    rst[0] = 1'b1; lv[0] = 1'b1; ld0 = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    rst[0] = 1'b0; lv[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_vs_load_busy", bsy[0], 1'b0);
    chk("rst_vs_load_rises", 64'(r0 - base), 64'd0);

    // load_valid held across two full transfers
    hs = 0; pulses = 0; t2 = 0; first_rx = '0;
    lv[0] = 1'b1; ld0 = 64'h1357_9BDF_0246_8ACE; t = cyc;
    for (int i = 0; i < 260; i++) begin
      if (i > 0) @(negedge clk);
      if (lv[0] && lr[0] === 1'b1) begin hs++; if (hs == 2) t2 = cyc; end
      if (rxv[0] === 1'b1) begin pulses++; if (pulses == 1) first_rx = rxd0; end
    end
    @(negedge clk);
    lv[0] = 1'b0;
    chk("t6_handshakes", 64'(hs), 64'd2);
    chk("t6_second_hs", 64'(t2 - t), 64'd130);
    chk("t6_rx_pulses", 64'(pulses), 64'd2);
    chk("t6_first_rxd", first_rx, 64'h0F1E_2D3C_4B5A_6978);
    repeat (5) @(negedge clk);
    chk("t6_idle", bsy[0], 1'b0);
    chk("t6_final_rxd", rxd0, 64'h1357_9BDF_0246_8ACE);
    chk("t6_chain", m0, 64'h1357_9BDF_0246_8ACE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
